// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: sequences req/ack imem fetches into a one-entry output register with a one-entry stall buffer.
// Optional PC legality checking is enabled with `define PC_CHECK_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] TEXT_LIMIT = 32'h0000_4FFC,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        pc_exc
);

`ifdef PC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        instr_valid_n;
  logic [31:0] instr_n, instr_pc_n;
  logic [31:0] buf_dat, buf_dat_n, buf_pc, buf_pc_n;
  logic        pend, pend_n;
  logic [31:0] pend_tgt, pend_tgt_n;
  logic        squash, squash_n;
  logic [31:0] sq_tgt, sq_tgt_n;
  logic        pc_exc_n;

  logic        consume, out_free, ds_hit, wp_hit;
  logic        load_en;
  logic [31:0] load_val;

  // Returns {exc, value}; an illegal value is replaced by the exception vector.
  function automatic logic [32:0] check_pc(input logic [31:0] v);
    logic bad;
    bad = (v != EXC_VECTOR) && ((v[1:0] != 2'b00) || (v < RESET_PC) || (v > TEXT_LIMIT));
    if (CHECK_EN && bad) return {1'b1, EXC_VECTOR};
    return {1'b0, v};
  endfunction

  assign consume   = instr_valid & ~stall;
  assign out_free  = ~instr_valid | consume;
  assign ds_hit    = redirect && (state == REQ) && (pc == redirect_pc + 32'd4);
  assign wp_hit    = redirect && (state == REQ) && (pc == redirect_pc + 32'd8);
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      buf_dat     <= 32'd0;
      buf_pc      <= 32'd0;
      pend        <= 1'b0;
      pend_tgt    <= 32'd0;
      squash      <= 1'b0;
      sq_tgt      <= 32'd0;
      pc_exc      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= instr_valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      buf_dat     <= buf_dat_n;
      buf_pc      <= buf_pc_n;
      pend        <= pend_n;
      pend_tgt    <= pend_tgt_n;
      squash      <= squash_n;
      sq_tgt      <= sq_tgt_n;
      pc_exc      <= pc_exc_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_valid_n = instr_valid;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    buf_dat_n     = buf_dat;
    buf_pc_n      = buf_pc;
    pend_n        = pend;
    pend_tgt_n    = pend_tgt;
    squash_n      = squash;
    sq_tgt_n      = sq_tgt;
    pc_exc_n      = 1'b0;
    load_en       = 1'b0;
    load_val      = pc;

    case (state)
      IDLE: state_n = REQ;

      REQ: begin
        if (wp_hit) begin
          squash_n = 1'b1;
          sq_tgt_n = redirect_target;
        end
        // Delay slot still in flight: remember where to go once it lands.
        if (ds_hit && !imem_ack) begin
          pend_n     = 1'b1;
          pend_tgt_n = redirect_target;
        end
        if (imem_ack) begin
          if (squash || wp_hit) begin
            squash_n = 1'b0;
            load_en  = 1'b1;
            load_val = wp_hit ? redirect_target : sq_tgt;
            if (consume) instr_valid_n = 1'b0;
          end else begin
            load_en  = 1'b1;
            load_val = ds_hit ? redirect_target : (pend ? pend_tgt : pc + 32'd4);
            pend_n   = 1'b0;
            if (out_free) begin
              instr_valid_n = 1'b1;
              instr_n       = imem_rdata;
              instr_pc_n    = pc;
            end else begin
              buf_dat_n = imem_rdata;
              buf_pc_n  = pc;
              state_n   = FULL;
            end
          end
        end else if (consume) begin
          instr_valid_n = 1'b0;
        end
      end

      FULL: begin
        if (consume) begin
          instr_valid_n = 1'b1;
          instr_n       = buf_dat;
          instr_pc_n    = buf_pc;
          state_n       = REQ;
        end
        // Delay slot is already buffered, so the target is the very next fetch.
        if (redirect) begin
          load_en  = 1'b1;
          load_val = redirect_target;
        end
      end

      default: state_n = IDLE;
    endcase

    if (load_en) {pc_exc_n, pc_n} = check_pc(load_val);
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed, table-driven bench for pc_fetch_sequencer: one row per clock of inputs and expected outputs.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, redirect_target, imem_rdata;
  logic        imem_req, instr_valid, pc_exc;
  logic [31:0] imem_addr, instr, instr_pc;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PC_CHECK_EN
  localparam logic [31:0] EXA = 32'h0000_4180;
  localparam logic        EXE = 1'b1;
`else
  localparam logic [31:0] EXA = 32'h0000_3002;
  localparam logic        EXE = 1'b0;
`endif

  pc_fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .pc_exc(pc_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] rpc, rtg;
    logic        ack;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] eipc;
    logic        eexc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic add(input logic rst, input logic stl, input logic rdr,
                     input logic [31:0] rpc, input logic [31:0] rtg, input logic ack,
                     input logic ereq, input logic [31:0] eaddr, input logic evld,
                     input logic [31:0] eipc, input logic eexc);
    vec_t v;
    v = '{rst, stl, rdr, rpc, rtg, ack, ereq, eaddr, evld, eipc, eexc};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    redirect_pc = '0; redirect_target = '0; imem_rdata = '0;

    //   rst stl rdr rpc           rtg           ack  req addr          vld ipc           exc
    add(0, 0, 0, 32'h0,       32'h0,       1,   0, 32'h0,       0, 32'h0,       0); // 0 IDLE
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3000,    0, 32'h0,       0); // 1
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3004,    1, 32'h3000,    0); // 2
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3008,    1, 32'h3004,    0); // 3
    add(0, 0, 0, 32'h0,       32'h0,       0,   1, 32'h300C,    1, 32'h3008,    0); // 4 ack delayed
    add(0, 1, 0, 32'h0,       32'h0,       0,   1, 32'h300C,    0, 32'h0,       0); // 5 stall, no valid
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h300C,    0, 32'h0,       0); // 6
    add(0, 1, 0, 32'h0,       32'h0,       1,   1, 32'h3010,    1, 32'h300C,    0); // 7 -> FULL
    add(0, 1, 0, 32'h0,       32'h0,       0,   0, 32'h0,       1, 32'h300C,    0); // 8
    add(0, 0, 0, 32'h0,       32'h0,       0,   0, 32'h0,       1, 32'h300C,    0); // 9 drain buf
    add(0, 0, 1, 32'h3010,    32'h3100,    0,   1, 32'h3014,    1, 32'h3010,    0); // 10 delay slot pend
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3014,    0, 32'h0,       0); // 11
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3100,    1, 32'h3014,    0); // 12
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3104,    1, 32'h3100,    0); // 13
    add(0, 0, 1, 32'h3100,    32'h3200,    0,   1, 32'h3108,    1, 32'h3104,    0); // 14 wrong path
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3108,    0, 32'h0,       0); // 15 squashed ack
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3200,    0, 32'h0,       0); // 16
    add(0, 0, 1, 32'h3200,    32'h3300,    1,   1, 32'h3204,    1, 32'h3200,    0); // 17 ds + same-cycle ack
    add(0, 1, 0, 32'h0,       32'h0,       1,   1, 32'h3300,    1, 32'h3204,    0); // 18 -> FULL
    add(0, 1, 1, 32'h3204,    32'h3400,    0,   0, 32'h0,       1, 32'h3204,    0); // 19 redirect in FULL
    add(0, 1, 1, 32'h3204,    32'h3400,    0,   0, 32'h0,       1, 32'h3204,    0); // 20 repeated
    add(0, 0, 1, 32'h3204,    32'h3400,    0,   0, 32'h0,       1, 32'h3204,    0); // 21
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3400,    1, 32'h3300,    0); // 22
    add(0, 0, 0, 32'h0,       32'h0,       0,   1, 32'h3404,    1, 32'h3400,    0); // 23
    add(1, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3404,    0, 32'h0,       0); // 24 reset mid-request
    add(0, 0, 0, 32'h0,       32'h0,       1,   0, 32'h0,       0, 32'h0,       0); // 25 IDLE ignores ack
    add(0, 0, 0, 32'h0,       32'h0,       1,   1, 32'h3000,    0, 32'h0,       0); // 26
    add(0, 0, 1, 32'h3000,    32'h3002,    1,   1, 32'h3004,    1, 32'h3000,    0); // 27 misaligned target
    add(0, 0, 0, 32'h0,       32'h0,       0,   1, EXA,         1, 32'h3004,    EXE); // 28
    add(0, 0, 0, 32'h0,       32'h0,       0,   1, EXA,         0, 32'h0,       0); // 29 pulse ends

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   -1, {31'd0, imem_req},    32'd0);
    chk("rst_addr",  -1, imem_addr,            32'h3000);
    chk("rst_vld",   -1, {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", -1, instr,                32'd0);
    chk("rst_ipc",   -1, instr_pc,             32'd0);
    chk("rst_exc",   -1, {31'd0, pc_exc},      32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset           = vecs[i].rst;
      stall           = vecs[i].stl;
      redirect        = vecs[i].rdr;
      redirect_pc     = vecs[i].rpc;
      redirect_target = vecs[i].rtg;
      imem_ack        = vecs[i].ack;
      imem_rdata      = rd(vecs[i].eaddr);
      @(negedge clk);
      chk("req", i, {31'd0, imem_req},    {31'd0, vecs[i].ereq});
      if (vecs[i].ereq) chk("addr", i, imem_addr, vecs[i].eaddr);
      chk("vld", i, {31'd0, instr_valid}, {31'd0, vecs[i].evld});
      if (vecs[i].evld) begin
        chk("ipc",   i, instr_pc, vecs[i].eipc);
        chk("instr", i, instr,    rd(vecs[i].eipc));
      end
      chk("exc", i, {31'd0, pc_exc}, {31'd0, vecs[i].eexc});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
